// File: rtl/ram_tx_streamer_pkg.sv
// Shared types and constants for the tweetboard RAM transmit path.
// Default timing constants are also used by the receiver side.
package tweet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam int VALID_BIT     = 15;
  localparam int FRAME_BITS    = 10;
  localparam int DATA_BITS     = 8;
  localparam int DEF_CLK_DIV   = 5208;
  localparam int DEF_MAX_CHARS = 160;

  // Baud counter width; a divider of 1 still needs one bit of state.
  function automatic int baud_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/ram_tx_streamer_if.sv
// Control, RAM read port and serial status bundle of the transmit streamer.
// slave = streamer side, master = RAM owner / controller side.
interface ram_tx_streamer_if #(
  parameter int ADDR_W = 8
);
  logic              go;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_rd_data;
  logic              serial_out;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   char_count;

  modport master (
    output go, ram_rd_data,
    input  ram_addr, serial_out, busy, done, char_count
  );

  modport slave (
    input  go, ram_rd_data,
    output ram_addr, serial_out, busy, done, char_count
  );
endinterface

// File: rtl/ram_tx_streamer_serializer.sv
// Baud counter, shift register and line driver for one 8N1 frame.
// The streamer FSM issues load/shift/stop/unload at each bit_done.
module tx_serializer
  import tweet_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift_bit,
  input  logic       send_stop,
  input  logic       unload,
  output logic       tx,
  output logic       busy,
  output logic       bit_done
);

  localparam int                BAUD_W    = baud_w(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  assign bit_done = busy_q && (baud_q == BAUD_LAST);
  assign tx       = tx_q;
  assign busy     = busy_q;

  always_comb begin
    baud_d  = baud_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    if (load) begin
      shreg_d = load_data;
      tx_d    = 1'b0;
      baud_d  = '0;
      busy_d  = 1'b1;
    end else if (shift_bit) begin
      tx_d    = shreg_q[0];
      shreg_d = {1'b0, shreg_q[7:1]};
      baud_d  = '0;
    end else if (send_stop) begin
      tx_d   = 1'b1;
      baud_d = '0;
    end else if (unload) begin
      tx_d   = 1'b1;
      baud_d = '0;
      busy_d = 1'b0;
    end else if (busy_q) begin
      baud_d = bit_done ? '0 : baud_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      baud_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      baud_q  <= baud_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/ram_tx_streamer.sv
// Walks the message RAM from address 0 and sends each stored character as
// an 8N1 frame, stopping at the first empty entry or at MAX_CHARS.
//
// state    | meaning
// ST_IDLE  | line high, waiting for go
// ST_WAIT  | RAM read latency after an address change
// ST_CHECK | stop on empty entry / limit, else load the serializer
// ST_START | start bit on the line
// ST_DATA  | data bits, LSB first
// ST_STOP  | stop bit; then advance address and count
module ram_tx_streamer
  import tweet_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int MAX_CHARS = DEF_MAX_CHARS,
  parameter int ADDR_W    = 8
) (
  input  logic                sysclk,
  input  logic                reset,
  ram_tx_streamer_if.slave    bus
);

  localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W + 1)'(MAX_CHARS);
  localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

  tx_state_e         state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_W:0]   char_count_q, char_count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic ser_load, ser_shift, ser_stop, ser_unload;
  logic ser_tx, ser_busy, ser_bit_done, step;
  logic [6:0] unused_rd_bits;

  assign unused_rd_bits = bus.ram_rd_data[14:8];
  assign step           = ser_busy && ser_bit_done;

  tx_serializer #(.CLK_DIV(CLK_DIV)) u_ser (
    .sysclk   (sysclk),
    .reset    (reset),
    .load     (ser_load),
    .load_data(bus.ram_rd_data[7:0]),
    .shift_bit(ser_shift),
    .send_stop(ser_stop),
    .unload   (ser_unload),
    .tx       (ser_tx),
    .busy     (ser_busy),
    .bit_done (ser_bit_done)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ram_addr_d   = ram_addr_q;
    char_count_d = char_count_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    ser_load     = 1'b0;
    ser_shift    = 1'b0;
    ser_stop     = 1'b0;
    ser_unload   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // a go coinciding with done is dropped; a fresh pulse is needed
        if (bus.go && !done_q) begin
          ram_addr_d   = '0;
          char_count_d = '0;
          busy_d       = 1'b1;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: state_d = ST_CHECK;
      ST_CHECK: begin
        if (!bus.ram_rd_data[VALID_BIT] || char_count_q == LIMIT) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          ser_load = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (step) begin
          ser_shift = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (step) begin
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            ser_stop = 1'b1;
            state_d  = ST_STOP;
          end else begin
            ser_shift = 1'b1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (step) begin
          ser_unload   = 1'b1;
          char_count_d = char_count_q + 1'b1;
          // hold at the top address so a full-RAM run never re-reads entry 0
          ram_addr_d   = (ram_addr_q == ADDR_TOP) ? ram_addr_q : ram_addr_q + 1'b1;
          state_d      = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      ram_addr_q   <= '0;
      char_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      ram_addr_q   <= ram_addr_d;
      char_count_q <= char_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.serial_out = ser_tx;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.char_count = char_count_q;

endmodule
